// File: rtl/expr_eval_arbiter.sv
// Round-robin front end that time-shares one fixed-latency expression evaluator
// among NREQ requesters, with a single transaction in flight at a time.
module expr_eval_arbiter #(
    parameter int NREQ = 4,
    parameter int OPW  = 60,
    parameter int RESW = 90,
    parameter int LAT  = 2,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*OPW-1:0]  req_ops,
    output logic [NREQ-1:0]      req_ready,
    output logic [OPW-1:0]       ev_ops,
    input  logic [RESW-1:0]      ev_res,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [RESW-1:0]      rsp_res,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic                 busy,
    output logic [CNTW-1:0]      done_cnt
);

    localparam int IDXW = $clog2(NREQ);
    localparam int CW   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDXW-1:0]    r_rr_ptr;
    logic [IDXW-1:0]    r_owner;
    logic [CW-1:0]      r_cnt;
    logic [OPW-1:0]     r_ev_ops;
    logic [RESW-1:0]    r_rsp_res;
    logic [NREQ-1:0]    r_rsp_valid;
    logic [CNTW-1:0]    r_done_cnt;

    logic [IDXW-1:0]    w_rot_idx [NREQ];
    logic [NREQ-1:0]    w_cand;
    logic [OPW-1:0]     w_ops [NREQ];
    logic [IDXW-1:0]    w_grant_idx;
    logic               w_found;
    logic [IDXW-1:0]    w_next_ptr;

    // Candidate k is requester (rr_ptr + k) mod NREQ; the extra bit keeps the sum exact.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [IDXW:0] w_sum;
            assign w_sum          = {1'b0, r_rr_ptr} + (IDXW+1)'(gi);
            assign w_rot_idx[gi]  = (w_sum >= (IDXW+1)'(NREQ)) ?
                                    IDXW'(w_sum - (IDXW+1)'(NREQ)) : IDXW'(w_sum);
            assign w_cand[gi]     = req_valid[w_rot_idx[gi]];
            assign w_ops[gi]      = req_ops[gi*OPW +: OPW];
        end
    endgenerate

    always_comb begin
        w_grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_cand[k]) begin
                w_grant_idx = w_rot_idx[k];
            end
        end
    end

    assign w_found    = |req_valid;
    assign w_next_ptr = (r_owner == IDXW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        req_ready = '0;
        if (!rst && (r_state == S_IDLE) && w_found) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_cnt       <= '0;
            r_ev_ops    <= '0;
            r_rsp_res   <= '0;
            r_rsp_valid <= '0;
            r_done_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_ev_ops <= w_ops[w_grant_idx];
                        r_owner  <= w_grant_idx;
                        r_cnt    <= CW'(LAT - 1);
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rsp_res            <= ev_res;
                        r_rsp_valid[r_owner] <= 1'b1;
                        r_state              <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Pointer moves only on completion so a grant alone never costs priority.
                    if (rsp_ready[r_owner]) begin
                        r_rsp_valid <= '0;
                        r_rr_ptr    <= w_next_ptr;
                        r_done_cnt  <= r_done_cnt + 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ev_ops    = r_ev_ops;
    assign rsp_res   = r_rsp_res;
    assign rsp_valid = r_rsp_valid;
    assign done_cnt  = r_done_cnt;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_expr_eval_arbiter.sv
// Directed bench for expr_eval_arbiter: NREQ=4, LAT=2, CNTW=4, stub evaluator y={30'b0,ops}.
module tb_expr_eval_arbiter;

    localparam int NREQ = 4;
    localparam int OPW  = 60;
    localparam int RESW = 90;
    localparam int LAT  = 2;
    localparam int CNTW = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*OPW-1:0] req_ops;
    logic [NREQ-1:0]     req_ready;
    logic [OPW-1:0]      ev_ops;
    logic [RESW-1:0]     ev_res;
    logic [NREQ-1:0]     rsp_valid;
    logic [RESW-1:0]     rsp_res;
    logic [NREQ-1:0]     rsp_ready;
    logic                busy;
    logic [CNTW-1:0]     done_cnt;

    int checks   = 0;
    int failures = 0;

    expr_eval_arbiter #(
        .NREQ(NREQ), .OPW(OPW), .RESW(RESW), .LAT(LAT), .CNTW(CNTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ops   (req_ops),
        .req_ready (req_ready),
        .ev_ops    (ev_ops),
        .ev_res    (ev_res),
        .rsp_valid (rsp_valid),
        .rsp_res   (rsp_res),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    assign ev_res = {30'b0, ev_ops};

    always #5 clk = ~clk;

    function automatic logic [OPW-1:0] opv(input int i, input int k);
        return {4'(i), 8'(k), 48'hA5A5_1234_5678};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        tick();
        tick();
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_req_ready got=%b exp=%b", req_ready, 4'b0000);
        end
        checks++;
        if ({busy, rsp_valid, done_cnt} !== 9'b0) begin
            failures++;
            $display("FAIL reset_ctrl got busy=%b rsp_valid=%b done_cnt=%0d exp all 0", busy, rsp_valid, done_cnt);
        end
        checks++;
        if ((ev_ops !== '0) || (rsp_res !== '0)) begin
            failures++;
            $display("FAIL reset_data got ev_ops=%h rsp_res=%h exp 0", ev_ops, rsp_res);
        end
        req_valid = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [OPW-1:0] ops;
        ops = 60'h0123456789ABCDE;
        rsp_ready = 4'b0001;
        req_ops[0 +: OPW] = ops;
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_grant got=%b exp=%b", req_ready, 4'b0001);
        end
        tick();
        req_valid = '0;
        checks++;
        if ((ev_ops !== ops) || (busy !== 1'b1) || (rsp_valid !== 4'b0)) begin
            failures++;
            $display("FAIL single_issue got ev_ops=%h busy=%b rsp_valid=%b exp ev_ops=%h busy=1 rsp_valid=0000",
                     ev_ops, busy, rsp_valid, ops);
        end
        tick();
        checks++;
        if (rsp_valid !== 4'b0000) begin
            failures++;
            $display("FAIL single_early_rsp got=%b exp=%b", rsp_valid, 4'b0000);
        end
        tick();
        checks++;
        if ((rsp_valid !== 4'b0001) || (rsp_res !== 90'h0123456789ABCDE)) begin
            failures++;
            $display("FAIL single_rsp got valid=%b res=%h exp valid=0001 res=%h", rsp_valid, rsp_res, 90'h0123456789ABCDE);
        end
        tick();
        checks++;
        if ((rsp_valid !== 4'b0) || (busy !== 1'b0) || (done_cnt !== 4'd1)) begin
            failures++;
            $display("FAIL single_accept got valid=%b busy=%b done_cnt=%0d exp 0000/0/1", rsp_valid, busy, done_cnt);
        end
        $display("txn single requester=0 res=%h done_cnt=%0d", rsp_res, done_cnt);
    endtask

    task automatic test_fairness();
        int exp_g [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
        rsp_ready = 4'b1111;
        req_valid = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NREQ; i++) req_ops[i*OPW +: OPW] = opv(i, t);
            #1;
            checks++;
            if (req_ready !== 4'(1 << exp_g[t])) begin
                failures++;
                $display("FAIL fair_grant[%0d] got=%b exp=%b", t, req_ready, 4'(1 << exp_g[t]));
            end
            tick();
            checks++;
            if ((req_ready !== 4'b0) || (ev_ops !== opv(exp_g[t], t))) begin
                failures++;
                $display("FAIL fair_wait[%0d] got ready=%b ev_ops=%h exp ready=0000 ev_ops=%h",
                         t, req_ready, ev_ops, opv(exp_g[t], t));
            end
            tick();
            tick();
            checks++;
            if ((rsp_valid !== 4'(1 << exp_g[t])) || (rsp_res !== {30'b0, opv(exp_g[t], t)})) begin
                failures++;
                $display("FAIL fair_rsp[%0d] got valid=%b res=%h exp valid=%b res=%h",
                         t, rsp_valid, rsp_res, 4'(1 << exp_g[t]), {30'b0, opv(exp_g[t], t)});
            end
            tick();
            $display("txn fair requester=%0d res=%h done_cnt=%0d", exp_g[t], rsp_res, done_cnt);
        end
        req_valid = '0;
        checks++;
        if (done_cnt !== 4'd9) begin
            failures++;
            $display("FAIL fair_done_cnt got=%0d exp=%0d", done_cnt, 9);
        end
    endtask

    task automatic test_ptr_wrap();
        logic [NREQ-1:0] vt [5] = '{4'b0100, 4'b0101, 4'b0101, 4'b1000, 4'b0101};
        int exp_g [5] = '{2, 0, 2, 3, 0};
        rsp_ready = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            req_valid = vt[t];
            for (int i = 0; i < NREQ; i++) req_ops[i*OPW +: OPW] = opv(i, 10 + t);
            #1;
            checks++;
            if (req_ready !== 4'(1 << exp_g[t])) begin
                failures++;
                $display("FAIL wrap_grant[%0d] got=%b exp=%b", t, req_ready, 4'(1 << exp_g[t]));
            end
            tick();
            tick();
            tick();
            checks++;
            if ((rsp_valid !== 4'(1 << exp_g[t])) || (rsp_res !== {30'b0, opv(exp_g[t], 10 + t)})) begin
                failures++;
                $display("FAIL wrap_rsp[%0d] got valid=%b res=%h exp valid=%b res=%h",
                         t, rsp_valid, rsp_res, 4'(1 << exp_g[t]), {30'b0, opv(exp_g[t], 10 + t)});
            end
            tick();
            $display("txn wrap requester=%0d res=%h done_cnt=%0d", exp_g[t], rsp_res, done_cnt);
        end
        req_valid = '0;
        checks++;
        if (done_cnt !== 4'd14) begin
            failures++;
            $display("FAIL wrap_done_cnt got=%0d exp=%0d", done_cnt, 14);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < NREQ; i++) req_ops[i*OPW +: OPW] = opv(i, 20);
        req_valid = 4'b1111;
        rsp_ready = 4'b1101;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL bp_grant got=%b exp=%b", req_ready, 4'b0010);
        end
        tick();
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ((rsp_valid !== 4'b0010) || (rsp_res !== {30'b0, opv(1, 20)}) ||
                (busy !== 1'b1) || (req_ready !== 4'b0)) begin
                failures++;
                $display("FAIL bp_hold[%0d] got valid=%b res=%h busy=%b ready=%b exp valid=0010 res=%h busy=1 ready=0000",
                         c, rsp_valid, rsp_res, busy, req_ready, {30'b0, opv(1, 20)});
            end
            req_ops[1*OPW +: OPW] = opv(1, 21 + c);
            tick();
        end
        rsp_ready = 4'b0010;
        tick();
        checks++;
        if ((rsp_valid !== 4'b0) || (done_cnt !== 4'd15) || (req_ready !== 4'b0100)) begin
            failures++;
            $display("FAIL bp_accept got valid=%b done_cnt=%0d ready=%b exp valid=0000 done_cnt=15 ready=0100",
                     rsp_valid, done_cnt, req_ready);
        end
        checks++;
        if (ev_ops !== opv(1, 20)) begin
            failures++;
            $display("FAIL bp_ev_ops_hold got=%h exp=%h", ev_ops, opv(1, 20));
        end
        $display("txn backpressure requester=1 res=%h done_cnt=%0d", rsp_res, done_cnt);
        req_valid = '0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_withdraw got busy=%b exp=0", busy);
        end
    endtask

    task automatic test_counter_wrap();
        logic [CNTW-1:0] exp_cnt [2] = '{4'd0, 4'd1};
        rsp_ready = 4'b0001;
        for (int t = 0; t < 2; t++) begin
            req_valid = 4'b0001;
            req_ops[0 +: OPW] = opv(0, 40 + t);
            #1;
            checks++;
            if (req_ready !== 4'b0001) begin
                failures++;
                $display("FAIL cnt_grant[%0d] got=%b exp=%b", t, req_ready, 4'b0001);
            end
            tick();
            tick();
            tick();
            checks++;
            if ((rsp_valid !== 4'b0001) || (rsp_res !== {30'b0, opv(0, 40 + t)})) begin
                failures++;
                $display("FAIL cnt_rsp[%0d] got valid=%b res=%h exp valid=0001 res=%h",
                         t, rsp_valid, rsp_res, {30'b0, opv(0, 40 + t)});
            end
            tick();
            checks++;
            if (done_cnt !== exp_cnt[t]) begin
                failures++;
                $display("FAIL cnt_value[%0d] got=%0d exp=%0d", t, done_cnt, exp_cnt[t]);
            end
            $display("txn counter requester=0 done_cnt=%0d", done_cnt);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_wait();
        rsp_ready = 4'b1111;
        req_ops[3*OPW +: OPW] = opv(3, 30);
        req_ops[0 +: OPW]     = opv(0, 31);
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL rstw_grant got=%b exp=%b", req_ready, 4'b1000);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rstw_busy got=%b exp=1", busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ((ev_ops !== '0) || (busy !== 1'b0) || (rsp_valid !== 4'b0) ||
            (done_cnt !== 4'd0) || (req_ready !== 4'b0)) begin
            failures++;
            $display("FAIL rstw_async got ev_ops=%h busy=%b valid=%b done_cnt=%0d ready=%b exp all 0",
                     ev_ops, busy, rsp_valid, done_cnt, req_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        req_valid = 4'b1111;
        #1;
        checks++;
        if ((req_ready !== 4'b0001) || (rsp_valid !== 4'b0)) begin
            failures++;
            $display("FAIL rstw_regrant got ready=%b valid=%b exp ready=0001 valid=0000", req_ready, rsp_valid);
        end
        tick();
        req_valid = '0;
        tick();
        tick();
        checks++;
        if ((rsp_valid !== 4'b0001) || (rsp_res !== {30'b0, opv(0, 31)})) begin
            failures++;
            $display("FAIL rstw_rsp got valid=%b res=%h exp valid=0001 res=%h", rsp_valid, rsp_res, {30'b0, opv(0, 31)});
        end
        tick();
        checks++;
        if (done_cnt !== 4'd1) begin
            failures++;
            $display("FAIL rstw_done_cnt got=%0d exp=%0d", done_cnt, 1);
        end
        $display("txn after_reset requester=0 res=%h done_cnt=%0d", rsp_res, done_cnt);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_ops   = '0;
        rsp_ready = '0;
        test_reset();
        test_single();
        test_fairness();
        test_ptr_wrap();
        test_backpressure();
        test_counter_wrap();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/expr_eval_arbiter.md
Name: expr_eval_arbiter

Overview:
- Shares one expression evaluator (60-bit operand bundle {a0..a5,b0..b5} in, 90-bit result y out) among NREQ requesters.
- Round-robin arbitration with valid/ready handshakes on both sides; one transaction outstanding at a time.
- Sits between the regression stimulus generators and a single evaluator instance, so several vector streams reuse one DUT.
- Waits a fixed evaluator latency, then returns the result to the owning requester.

Parameters:
- NREQ, 4, number of requesters (2..8)
- OPW, 60, operand bundle width (sum of a0..b5 widths)
- RESW, 90, evaluator result width
- LAT, 2, cycles ev_ops must be held stable before ev_res is sampled (1..15; 0 illegal)
- CNTW, 16, width of completed-transaction counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ops  in  NREQ*OPW  operand bundles; requester i occupies [i*OPW +: OPW]
- req_ready  out  NREQ  grant/accept strobe, one-hot or zero
- ev_ops  out  OPW  operand bundle driven to evaluator
- ev_res  in  RESW  evaluator result
- rsp_valid  out  NREQ  result valid, one-hot to owner
- rsp_res  out  RESW  captured result
- rsp_ready  in  NREQ  per-requester result accept
- busy  out  1  high whenever state != IDLE
- done_cnt  out  CNTW  completed transactions, wraps modulo 2^CNTW

Behaviour:
- Clock and reset: one clock clk; rst is asynchronous, active-high.
- Reset values: state=IDLE, rr_ptr=0, owner=0, wait counter=0, ev_ops=0, rsp_res=0, rsp_valid=0, done_cnt=0, busy=0. req_ready=0 while rst is high.
- States: IDLE, WAIT, RESP.
- Arbitration in IDLE: g = first index with req_valid set, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NREQ.
  - req_ready[g] is combinational and equals state==IDLE && any req_valid; all other req_ready bits are 0.
  - Handshake completes in the same cycle.
- Issue edge (IDLE with a grant): ev_ops<=req_ops[g]; owner<=g; cnt<=LAT-1; go to WAIT.
- WAIT:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: rsp_res<=ev_res; rsp_valid[owner]<=1; go to RESP.
  - ev_ops is therefore stable for exactly LAT cycles before sampling.
  - rsp_valid rises LAT cycles after the issue edge.
- RESP:
  - rsp_valid and rsp_res are held until rsp_ready[owner]=1. rsp_ready bits of non-owners are ignored.
  - On acceptance: rsp_valid<=0; rr_ptr<=(owner+1) mod NREQ; done_cnt<=done_cnt+1; go to IDLE.
- Minimum period per transaction is LAT+2 cycles. No grant is issued in the RESP acceptance cycle.
- ev_ops holds its last bundle after completion; it is not cleared. rsp_res holds its last value while rsp_valid=0.
- Requesters must hold req_valid and req_ops until granted. A withdrawn request is simply not granted and is not an error.
- req_ops are sampled only on the issue edge. Changes while in WAIT or RESP have no effect.
- rr_ptr advances only on completion, never on grant alone. A requester re-asserting right after its own completion therefore gets lowest priority.
- rst asserted in WAIT or RESP aborts immediately: the response is dropped, the counter is not incremented, and rr_ptr returns to 0.
- Counter: done_cnt wraps from 2^CNTW-1 to 0 without a flag.
- Width rules: all indices are unsigned with width clog2(NREQ). The operand slice is taken unsigned; signedness of the sub-fields is the evaluator's concern.

Test Plan:
- Single request: NREQ=4, LAT=2. req_valid=0001, ops=60'h0123456789ABCDE, stub ev_res = {30'b0, ev_ops} -> req_ready=0001 in cycle 0, ev_ops=ops from cycle 1, rsp_valid=0001 at cycle 3 with rsp_res=90'h0123456789ABCDE, done_cnt=1 after accept.
- Fairness: req_valid=1111 held for 8 transactions with rsp_ready=1111 -> grant order 0,1,2,3,0,1,2,3; each transaction 4 cycles apart; done_cnt=8.
- Pointer wrap with sparse requests: rr_ptr=3 after servicing requester 2, req_valid=0101 -> grant 0, then 2; with req_valid=1000 only -> grant 3, then rr_ptr=0.
- Backpressure: rsp_ready[owner]=0 for 5 cycles -> rsp_valid and rsp_res stable and busy=1 throughout, no new req_ready even with other req_valid high; accept on cycle 6 -> next grant the cycle after.
- Reset mid-WAIT: LAT=4, assert rst 2 cycles after issue -> all outputs 0 asynchronously, no rsp_valid, done_cnt unchanged at 0; next request granted starting from index 0.
- Counter wrap: CNTW=4, 17 transactions -> done_cnt sequence reaches 15 then 0, ending at 1.
